// File: rtl/afc_ctr_pair.sv
// Dual-clock AFC measurement counters: a reference counter and a PLL feedback counter
// that count to 64 << winSel and report sticky done flags back in the ckref domain.
module afc_ctr_pair #(
  parameter int CW = 10
) (
  input  logic          ckref,
  input  logic          ckfb,
  input  logic          reset,
  input  logic          ctrReset,
  input  logic          ctrEnable,
  input  logic [1:0]    winSel,
  output logic          ckrefDone,
  output logic          ckfbDone,
  output logic [CW-1:0] fbCount,
  inout  wire           VDD,
  inout  wire           VSS
);

  function automatic logic [CW-1:0] gray2bin(input logic [CW-1:0] g);
    logic [CW-1:0] b;
    for (int i = 0; i < CW; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  wire unusedSupply = VDD ^ VSS;

  logic [CW-1:0] target;
  assign target = {{(CW-7){1'b0}}, 7'd64} << winSel;

  // ---------------- ckref domain ----------------
  logic          clrTog, clrRefS1, clrRefS2, clrRefD;
  logic          enRefS1, refEn, refArmed, refRawDone;
  logic          refDoneS1, fbDoneS1;
  logic [CW-1:0] refCnt, refCntNxt, fbGrayS1, fbGrayS2;
  logic          refClear;

  // fb-domain state seen by the ckref side
  logic          fbRawDone;
  logic [CW-1:0] fbGray;

  assign refClear = clrRefS2 ^ clrRefD;

  always_comb begin
    refCntNxt = refCnt;
    if (refClear)
      refCntNxt = '0;
    else if (refEn && refArmed && !refRawDone)
      refCntNxt = refCnt + 1'b1;
  end

  // refArmed stays low after reset until a clear arrives, so a reset mid-count
  // cannot restart a measurement on its own while ctrEnable is still high.
  always_ff @(posedge ckref) begin
    if (reset) begin
      clrTog     <= 1'b0;
      clrRefS1   <= 1'b0;
      clrRefS2   <= 1'b0;
      clrRefD    <= 1'b0;
      enRefS1    <= 1'b0;
      refEn      <= 1'b0;
      refArmed   <= 1'b0;
      refCnt     <= '0;
      refRawDone <= 1'b0;
      refDoneS1  <= 1'b0;
      ckrefDone  <= 1'b0;
      fbDoneS1   <= 1'b0;
      ckfbDone   <= 1'b0;
      fbGrayS1   <= '0;
      fbGrayS2   <= '0;
    end else begin
      clrTog     <= clrTog ^ ctrReset;
      clrRefS1   <= clrTog;
      clrRefS2   <= clrRefS1;
      clrRefD    <= clrRefS2;
      enRefS1    <= ctrEnable;
      refEn      <= enRefS1;
      if (refClear) refArmed <= 1'b1;
      refCnt     <= refCntNxt;
      refRawDone <= !refClear && (refRawDone || (refCntNxt == target));
      refDoneS1  <= refRawDone;
      ckrefDone  <= refDoneS1;
      fbDoneS1   <= fbRawDone;
      ckfbDone   <= fbDoneS1;
      fbGrayS1   <= fbGray;
      fbGrayS2   <= fbGrayS1;
    end
  end

  assign fbCount = gray2bin(fbGrayS2);

  // ---------------- ckfb domain ----------------
  logic          fbRstS1, fbRst;
  logic          clrFbS1, clrFbS2, clrFbD;
  logic          enFbS1, fbEn, fbArmed;
  logic [CW-1:0] fbCnt, fbCntNxt;
  logic          fbClear;

  always_ff @(posedge ckfb) begin
    fbRstS1 <= reset;
    fbRst   <= fbRstS1;
  end

  assign fbClear = clrFbS2 ^ clrFbD;

  always_comb begin
    fbCntNxt = fbCnt;
    if (fbClear)
      fbCntNxt = '0;
    else if (fbEn && fbArmed && !fbRawDone)
      fbCntNxt = fbCnt + 1'b1;
  end

  // Gray is taken from the next count so the snapshot does not lag the counter.
  always_ff @(posedge ckfb) begin
    if (fbRst) begin
      clrFbS1   <= 1'b0;
      clrFbS2   <= 1'b0;
      clrFbD    <= 1'b0;
      enFbS1    <= 1'b0;
      fbEn      <= 1'b0;
      fbArmed   <= 1'b0;
      fbCnt     <= '0;
      fbRawDone <= 1'b0;
      fbGray    <= '0;
    end else begin
      clrFbS1   <= clrTog;
      clrFbS2   <= clrFbS1;
      clrFbD    <= clrFbS2;
      enFbS1    <= ctrEnable;
      fbEn      <= enFbS1;
      if (fbClear) fbArmed <= 1'b1;
      fbCnt     <= fbCntNxt;
      fbRawDone <= !fbClear && (fbRawDone || (fbCntNxt == target));
      fbGray    <= fbCntNxt ^ (fbCntNxt >> 1);
    end
  end

endmodule

// File: tb/tb_afc_ctr_pair.sv
// Bench for afc_ctr_pair: measures done-flag edge numbers and fbCount snapshots
// across clock ratios, clears, resets and enable gaps.
`timescale 1ns/10ps
module tb_afc_ctr_pair;
  localparam int CW = 10;

  logic          ckref = 1'b0;
  logic          ckfb = 1'b0;
  logic          reset = 1'b1;
  logic          ctrReset = 1'b0;
  logic          ctrEnable = 1'b0;
  logic [1:0]    winSel = 2'd0;
  logic          ckrefDone, ckfbDone;
  logic [CW-1:0] fbCount;
  wire           vdd = 1'b1;
  wire           vss = 1'b0;

  realtime       fbHalf = 12.5;
  int            checks = 0;
  int            errors = 0;
  logic [31:0]   exp_q[$];
  int            refEdge, fbEdge, doneSeen;
  logic          probeRef, probeFb;

  afc_ctr_pair #(.CW(CW)) dut (
    .ckref(ckref), .ckfb(ckfb), .reset(reset), .ctrReset(ctrReset),
    .ctrEnable(ctrEnable), .winSel(winSel), .ckrefDone(ckrefDone),
    .ckfbDone(ckfbDone), .fbCount(fbCount), .VDD(vdd), .VSS(vss)
  );

  // clock / reset block
  always #12.5 ckref = ~ckref;
  initial begin
    #7;
    forever #(fbHalf) ckfb = ~ckfb;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge ckref);
  endtask

  task automatic clear_pulse();
    @(negedge ckref) ctrReset = 1'b1;
    @(negedge ckref) ctrReset = 1'b0;
  endtask

  // Raise ctrEnable; edge 1 is the ckref edge that first samples it.
  task automatic run_enable(input int maxCyc, input int probeAt,
                            output int rEdge, output int fEdge,
                            output logic pRef, output logic pFb);
    rEdge = -1;
    fEdge = -1;
    pRef  = 1'b0;
    pFb   = 1'b0;
    @(negedge ckref) ctrEnable = 1'b1;
    for (int n = 1; n <= maxCyc; n++) begin
      @(posedge ckref);
      #1;
      if (ckrefDone && rEdge < 0) rEdge = n;
      if (ckfbDone && fEdge < 0) fEdge = n;
      if (n == probeAt) begin
        pRef = ckrefDone;
        pFb  = ckfbDone;
      end
      if (rEdge >= 0 && fEdge >= 0 && n >= probeAt) break;
    end
  endtask

  // Pulse ctrReset; report first edge where each done reaches 'level'.
  task automatic pulse_watch(input int maxCyc, input logic level,
                             output int rEdge, output int fEdge);
    rEdge = -1;
    fEdge = -1;
    @(negedge ckref) ctrReset = 1'b1;
    for (int n = 1; n <= maxCyc; n++) begin
      @(posedge ckref);
      #1;
      if (ckrefDone === level && rEdge < 0) rEdge = n;
      if (ckfbDone === level && fEdge < 0) fEdge = n;
      @(negedge ckref) ctrReset = 1'b0;
      if (rEdge >= 0 && fEdge >= 0) break;
    end
  endtask

  initial begin
    // reset state
    idle(10);
    reset = 1'b0;
    idle(5);
    chk("rst_ckrefDone", ckrefDone, 0);
    chk("rst_ckfbDone", ckfbDone, 0);
    chk("rst_fbCount", fbCount, 0);

    // equal clocks, T=64
    clear_pulse();
    idle(10);
    exp_q.push_back(68);
    exp_q.push_back(64);
    run_enable(200, 0, refEdge, fbEdge, probeRef, probeFb);
    chk("eq_ref_rise", refEdge, exp_q.pop_front());
    chk($sformatf("eq_fb_rise_%0d_in_67_69", fbEdge), (fbEdge >= 67 && fbEdge <= 69), 1);
    idle(4);
    chk("eq_fbCount", fbCount, exp_q.pop_front());

    // ckfb = 2x ckref, T=128
    @(negedge ckref) ctrEnable = 1'b0;
    idle(5);
    fbHalf = 6.25;
    winSel = 2'd1;
    clear_pulse();
    idle(10);
    exp_q.push_back(132);
    exp_q.push_back(128);
    run_enable(300, 0, refEdge, fbEdge, probeRef, probeFb);
    chk("fast_ref_rise", refEdge, exp_q.pop_front());
    chk($sformatf("fast_lead_%0d_in_60_68", refEdge - fbEdge),
        ((refEdge - fbEdge) >= 60 && (refEdge - fbEdge) <= 68), 1);
    idle(4);
    chk("fast_fbCount", fbCount, exp_q.pop_front());

    // both done, enable dropped (flags retained), then clear with ckfb = ckref/4
    @(negedge ckref) ctrEnable = 1'b0;
    fbHalf = 50.0;
    idle(15);
    chk("hold_ckrefDone", ckrefDone, 1);
    chk("hold_ckfbDone", ckfbDone, 1);
    exp_q.push_back(6);
    exp_q.push_back(0);
    pulse_watch(40, 1'b0, refEdge, fbEdge);
    chk("slowclr_ref_fall", refEdge, exp_q.pop_front());
    chk($sformatf("slowclr_fb_fall_%0d_in_6_16", fbEdge), (fbEdge >= 6 && fbEdge <= 16), 1);
    idle(20);
    chk("slowclr_fbCount", fbCount, exp_q.pop_front());

    // ckfb = ckref/3, T=512: no wrap, fb still busy at cycle 1000
    fbHalf = 37.5;
    winSel = 2'd3;
    idle(10);
    exp_q.push_back(516);
    exp_q.push_back(512);
    run_enable(1700, 1000, refEdge, fbEdge, probeRef, probeFb);
    chk("slow_ref_rise", refEdge, exp_q.pop_front());
    chk("slow_ref_held_1000", probeRef, 1);
    chk("slow_fb_low_1000", probeFb, 0);
    chk($sformatf("slow_fb_rise_%0d_in_1535_1555", fbEdge), (fbEdge >= 1535 && fbEdge <= 1555), 1);
    idle(10);
    chk("slow_fbCount", fbCount, exp_q.pop_front());

    // reset at ref count 200 (T=256), equal clocks
    @(negedge ckref) ctrEnable = 1'b0;
    fbHalf = 12.5;
    idle(5);
    clear_pulse();
    idle(10);
    winSel = 2'd2;
    @(negedge ckref) ctrEnable = 1'b1;
    repeat (202) @(posedge ckref);
    @(negedge ckref) reset = 1'b1;
    @(posedge ckref);
    #1;
    chk("midrst_ckrefDone", ckrefDone, 0);
    chk("midrst_ckfbDone", ckfbDone, 0);
    chk("midrst_fbCount", fbCount, 0);
    idle(8);
    reset = 1'b0;
    doneSeen = 0;
    for (int n = 0; n < 600; n++) begin
      @(posedge ckref);
      #1;
      if (ckrefDone || ckfbDone || fbCount != 0) doneSeen++;
    end
    chk("midrst_quiet_cycles", doneSeen, 0);
    exp_q.push_back(262);
    pulse_watch(400, 1'b1, refEdge, fbEdge);
    chk("midrst_rearm_ref_rise", refEdge, exp_q.pop_front());
    chk($sformatf("midrst_rearm_fb_rise_%0d_in_259_264", fbEdge), (fbEdge >= 259 && fbEdge <= 264), 1);

    // enable gap of 20 cycles after ref count 50, T=64
    @(negedge ckref) ctrEnable = 1'b0;
    idle(5);
    clear_pulse();
    idle(10);
    winSel = 2'd0;
    exp_q.push_back(88);
    refEdge = -1;
    fbEdge = -1;
    @(negedge ckref) ctrEnable = 1'b1;
    for (int n = 1; n <= 150; n++) begin
      @(posedge ckref);
      #1;
      if (ckrefDone && refEdge < 0) refEdge = n;
      if (ckfbDone && fbEdge < 0) fbEdge = n;
      if (n == 60) begin
        chk($sformatf("gap_fbCount_%0d_in_49_51", fbCount), (fbCount >= 49 && fbCount <= 51), 1);
        chk("gap_ckrefDone", ckrefDone, 0);
      end
      @(negedge ckref);
      if (n == 50) ctrEnable = 1'b0;
      if (n == 70) ctrEnable = 1'b1;
      if (refEdge >= 0 && fbEdge >= 0) break;
    end
    chk("gap_ref_rise", refEdge, exp_q.pop_front());
    chk($sformatf("gap_fb_rise_%0d_in_87_89", fbEdge), (fbEdge >= 87 && fbEdge <= 89), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
